// File: rtl/dma_rd_engine.sv
// DMA read channel: issues cache-line reads and buffers in-order responses for the AFU.
// Optional DMA_RD_STATS_EN adds the stall_cycles request-stall counter output.
module dma_rd_engine #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 43,
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-7:0] req_addr,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data
`ifdef DMA_RD_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-7:0] line_addr_reg;
    logic [SIZE_WIDTH-1:0] req_left_reg;
    logic [SIZE_WIDTH-1:0] pop_left_reg;
    logic [CW-1:0]         outstanding_reg;
    logic [CW-1:0]         fifo_count_reg;
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  go_accept;
    logic                  req_fire;
    logic                  pop;
    logic [CW:0]           credit_sum;
    logic                  addr_offset_unused;

    assign addr_offset_unused = ^rd_addr[5:0];

    assign go_accept  = rd_go && ((state_reg == IDLE) || (state_reg == DONE));
    // Credits cover both buffered lines and lines still in flight, so pushes never overflow.
    assign credit_sum = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
    assign req_valid  = (state_reg == REQ) && (req_left_reg != '0) &&
                        (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign req_fire   = req_valid && req_ready;
    assign req_addr   = line_addr_reg;
    assign empty      = (fifo_count_reg == '0);
    assign pop        = rd_en && !empty;
    assign rd_data    = empty ? '0 : mem[rd_ptr_reg];
    assign rd_done    = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (rd_go) begin
                    state_next = (rd_size == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (req_fire && (req_left_reg == SIZE_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((pop_left_reg == '0) || (pop && (pop_left_reg == SIZE_WIDTH'(1)))) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            line_addr_reg   <= '0;
            req_left_reg    <= '0;
            pop_left_reg    <= '0;
            outstanding_reg <= '0;
            fifo_count_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (go_accept) begin
                line_addr_reg <= rd_addr[ADDR_WIDTH-1:6];
                req_left_reg  <= rd_size;
                pop_left_reg  <= rd_size;
            end else begin
                if (req_fire) begin
                    line_addr_reg <= line_addr_reg + 1'b1;
                    req_left_reg  <= req_left_reg - 1'b1;
                end
                if (pop) begin
                    pop_left_reg <= pop_left_reg - 1'b1;
                end
            end
            case ({req_fire, rsp_valid})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
            case ({rsp_valid, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
            if (rsp_valid) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; rd_data is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (rsp_valid) begin
            mem[wr_ptr_reg] <= rsp_data;
        end
    end

`ifdef DMA_RD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (go_accept) begin
            stall_cycles <= '0;
        end else if ((state_reg == REQ) && (req_left_reg != '0) && !req_fire &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_rd_engine.sv
// Scoreboard bench for dma_rd_engine with a fixed-latency in-order memory model.
// Define DMA_RD_STATS_EN to also exercise the stall_cycles counter.
module tb_dma_rd_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_go = 1'b0;
    logic [63:0]  rd_addr = '0;
    logic [42:0]  rd_size = '0;
    logic         rd_en = 1'b0;
    logic [511:0] rd_data;
    logic         empty;
    logic         rd_done;
    logic         req_valid;
    logic [57:0]  req_addr;
    logic         req_ready = 1'b0;
    logic         rsp_valid = 1'b0;
    logic [511:0] rsp_data = '0;
`ifdef DMA_RD_STATS_EN
    logic [31:0]  stall_cycles;
`endif

    dma_rd_engine dut (
        .clk(clk), .rst(rst), .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef DMA_RD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [57:0] addr;
    } pend_t;

    pend_t        pend_q[$];
    logic [511:0] sb_q[$];
    logic [57:0]  exp_addr_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nreq = 0;
    int pops = 0;
    int last_pop = 0;
    bit ready_mode = 1'b1;
    bit auto_pop = 1'b1;
    bit force_pop = 1'b0;
    bit one_pop = 1'b0;
    bit go_pend = 1'b0;

    function automatic logic [511:0] mk(input logic [57:0] a);
        logic [63:0] w;
        w = {6'b0, a} ^ 64'hC3A5_5A3C_0F0F_F0F0;
        return {w, ~w, w + 64'd1, w ^ 64'hFF, w, ~w, w - 64'd1, w};
    endfunction

    // One bench cycle: drive inputs at the falling edge, model memory, score pops and requests.
    task automatic cycle();
        pend_t        e;
        logic [511:0] exp_d;
        logic [57:0]  exp_a;
        @(negedge clk);
        cyc++;
        rd_go = go_pend;
        go_pend = 1'b0;
        req_ready = ready_mode;
        rsp_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            e = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data = mk(e.addr);
            sb_q.push_back(rsp_data);
        end
        rd_en = force_pop || ((auto_pop || one_pop) && !empty);
        if (one_pop && !empty) one_pop = 1'b0;
        if (rd_en && !empty) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %h required no data (unexpected pop)", rd_data[63:0]);
            end else begin
                exp_d = sb_q.pop_front();
                if (rd_data !== exp_d) begin
                    errors++;
                    $display("FAIL pop_data: got %h required %h", rd_data[63:0], exp_d[63:0]);
                end else begin
                    $display("pop  cyc=%0d data=%h", cyc, rd_data[63:0]);
                end
            end
            pops++;
            last_pop = cyc;
        end
        if (req_valid && req_ready) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL req_addr: got %h required no request", req_addr);
            end else begin
                exp_a = exp_addr_q.pop_front();
                if (req_addr !== exp_a) begin
                    errors++;
                    $display("FAIL req_addr: got %h required %h", req_addr, exp_a);
                end else begin
                    $display("req  cyc=%0d addr=%h", cyc, req_addr);
                end
            end
            pend_q.push_back('{due: cyc + 2, addr: req_addr});
            nreq++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_go = 1'b0;
        rd_en = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        go_pend = 1'b0;
        one_pop = 1'b0;
        force_pop = 1'b0;
        pend_q.delete();
        sb_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start(input logic [63:0] a, input logic [42:0] s);
        rd_addr = a;
        rd_size = s;
        go_pend = 1'b1;
        pops = 0;
        nreq = 0;
        for (int i = 0; i < int'(s); i++) exp_addr_q.push_back(a[63:6] + 58'(i));
    endtask

    task automatic run_to_done(input string name, input int budget, input int exp_pops);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            cycle();
            n++;
            if (rd_done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_timeout: got rd_done=0 after %0d cycles required 1", name, n);
        end else begin
            checks++;
            if (cyc !== last_pop + 1) begin
                errors++;
                $display("FAIL %s_done_latency: got cycle %0d required %0d", name, cyc, last_pop + 1);
            end
        end
        checks++;
        if (pops !== exp_pops || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pops: got %0d (left %0d) required %0d", name, pops, sb_q.size(), exp_pops);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_valid !== 1'b0 || req_addr !== '0 || empty !== 1'b1 ||
            rd_done !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got rv=%b ra=%h e=%b d=%b rdata_nz=%b required 0 0 1 0 0",
                     req_valid, req_addr, empty, rd_done, |rd_data);
        end
    endtask

    task automatic test_basic();
        do_reset();
        ready_mode = 1'b1;
        auto_pop = 1'b1;
        start(64'h1000, 43'd4);
        cycle();
        cycle();
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_req: got req_valid=%b required 1", req_valid);
        end
        run_to_done("basic", 100, 4);
        checks++;
        if (nreq !== 4) begin
            errors++;
            $display("FAIL basic_nreq: got %0d required 4", nreq);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        ready_mode = 1'b1;
        auto_pop = 1'b0;
        start(64'h2_0000, 43'd40);
        repeat (40) cycle();
        checks++;
        if (nreq !== 16 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit_limit: got nreq=%0d rv=%b required 16 0", nreq, req_valid);
        end
        one_pop = 1'b1;
        repeat (10) cycle();
        checks++;
        if (nreq !== 17 || req_valid !== 1'b0 || pops !== 1) begin
            errors++;
            $display("FAIL bp_one_more: got nreq=%0d rv=%b pops=%0d required 17 0 1", nreq, req_valid, pops);
        end
        auto_pop = 1'b1;
    endtask

    task automatic test_zero_size();
        int base;
        do_reset();
        start(64'h5000, 43'd0);
        cycle();
        checks++;
        if (rd_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_early: got rd_done=%b required 0", rd_done);
        end
        base = nreq;
        cycle();
        checks++;
        if (rd_done !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got rd_done=%b rv=%b required 1 0", rd_done, req_valid);
        end
        repeat (5) cycle();
        checks++;
        if (nreq !== base || rd_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_no_req: got nreq=%0d done=%b required %0d 1", nreq, rd_done, base);
        end
    endtask

    task automatic test_illegal_pop_ignored_go();
        int n;
        do_reset();
        ready_mode = 1'b1;
        force_pop = 1'b1;
        repeat (3) cycle();
        checks++;
        if (empty !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL underflow_idle: got empty=%b required 1", empty);
        end
        start(64'h2000, 43'd6);
        n = 0;
        while (nreq < 2 && n < 20) begin
            cycle();
            n++;
        end
        rd_addr = 64'h9000;
        rd_size = 43'd3;
        go_pend = 1'b1;
        run_to_done("ignored_go", 100, 6);
        checks++;
        if (nreq !== 6 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ignored_go_nreq: got nreq=%0d empty=%b required 6 1", nreq, empty);
        end
        force_pop = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        do_reset();
        ready_mode = 1'b1;
        auto_pop = 1'b0;
        start(64'h3000, 43'd8);
        n = 0;
        while (nreq < 3 && n < 20) begin
            cycle();
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got empty=%b required 0", empty);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || req_valid !== 1'b0 || rd_done !== 1'b0 || req_addr !== '0) begin
            errors++;
            $display("FAIL midrst_clear: got e=%b rv=%b d=%b ra=%h required 1 0 0 0",
                     empty, req_valid, rd_done, req_addr);
        end
        do_reset();
        auto_pop = 1'b1;
        start(64'h4000, 43'd5);
        cycle();
        run_to_done("post_reset", 100, 5);
    endtask

`ifdef DMA_RD_STATS_EN
    task automatic test_stats();
        do_reset();
        auto_pop = 1'b1;
        ready_mode = 1'b0;
        start(64'h6000, 43'd4);
        cycle();
        repeat (5) cycle();
        ready_mode = 1'b1;
        run_to_done("stats", 100, 4);
        checks++;
        if (stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL stats_count: got %0d required 5", stall_cycles);
        end
        start(64'h7000, 43'd0);
        cycle();
        cycle();
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d required 0", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_zero_size();
        test_illegal_pop_ignored_go();
        test_reset_mid_transfer();
`ifdef DMA_RD_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_rd_engine.md
# dma_rd_engine

Read channel of the DMA engine: the responder side of the DMA read interface used by AFUs. Latches a starting virtual byte address and a cache-line count on `rd_go`, then issues one cache-line read per request to the host memory port. Buffers in-order responses in a credit-limited FIFO and presents them to the AFU with `empty`/`rd_en`/`rd_data` semantics. Sits between the AFU's DMA read port and the HAL's memory request/response channel.

## Interface
- `ADDR_WIDTH`, 64: virtual byte address width.
- `SIZE_WIDTH`, 43: transfer size width, in cache lines.
- `DATA_WIDTH`, 512: cache-line width.
- `FIFO_DEPTH`, 16: response buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_go` in 1: start pulse, sampled in IDLE or DONE.
- `rd_addr` in ADDR_WIDTH: starting byte address; bits [5:0] ignored.
- `rd_size` in SIZE_WIDTH: number of cache lines to transfer.
- `rd_en` in 1: AFU pops the head entry.
- `rd_data` out DATA_WIDTH: FIFO head (show-ahead); valid when `empty`=0.
- `empty` out 1: no data available.
- `rd_done` out 1: all `rd_size` lines consumed by the AFU.
- `req_valid` out 1: memory read request valid.
- `req_addr` out ADDR_WIDTH-6: cache-line address of the request.
- `req_ready` in 1: memory port accepts the request when high with `req_valid`.
- `rsp_valid` in 1: read response valid. Responses return in request order and cannot be back-pressured.
- `rsp_data` in DATA_WIDTH: response cache line.

## Operation
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE or DONE with `rd_go`=1:
  - Latch `line_addr = rd_addr[ADDR_WIDTH-1:6]`, `req_left = rd_size`, `pop_left = rd_size`.
  - Clear `rd_done`.
  - Go to REQ, or directly to DONE if `rd_size`=0.
- REQ:
  - `req_valid` = (`req_left`≠0) && (`outstanding` + `fifo_count` < FIFO_DEPTH).
  - On handshake: `line_addr`+1 (wraps modulo 2^(ADDR_WIDTH-6)), `req_left`−1, `outstanding`+1.
  - Go to DRAIN when the last request handshakes.
- Any state: `rsp_valid` pushes `rsp_data` and decrements `outstanding`. The credit rule guarantees the FIFO never overflows.
- `rd_en` with `empty`=0: pops the FIFO and decrements `pop_left`. `rd_en` with `empty`=1 is ignored: no pointer or counter change.
- DRAIN: go to DONE when `pop_left` reaches 0.
- DONE: `rd_done`=1 held until the next accepted `rd_go`.
- `rd_go` in REQ or DRAIN is ignored. Latched values and counters are unchanged.
- Counters `outstanding` and `fifo_count` are $clog2(FIFO_DEPTH)+1 bits. `req_left` and `pop_left` are SIZE_WIDTH bits.
- Reset mid-transfer: state→IDLE; FIFO, counters and outputs cleared. The memory port shares `rst`, so no stale responses arrive afterwards.

## Timing
- Reset values: `req_valid`=0, `req_addr`=0, `empty`=1, `rd_done`=0, `rd_data`=0.
- `rd_go` at cycle N: first `req_valid`=1 at N+1 (registered state).
- Peak throughput: one request per cycle, and one pop per cycle concurrent with one push.
- Response at cycle M: `empty`=0 at M+1; `rd_data` valid the same cycle.
- Push and pop in the same cycle: `fifo_count` unchanged; data order preserved.
- Pop of the final line at cycle K: `rd_done`=1 at K+1.
- `rd_size`=0 at cycle N: `rd_done`=1 at N+1; no request issued.
- `req_valid` and `req_addr` stay stable while `req_ready`=0.

## Configuration
- `DMA_RD_STATS_EN` defined: adds output `stall_cycles` [31:0].
  - Increments each cycle in REQ with `req_left`≠0 and no request issued, whether blocked by `req_ready`=0 or by credits.
  - Saturates at 2^32−1; cleared to 0 on an accepted `rd_go` and on reset.
- `DMA_RD_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Basic transfer:
  - Stimulus: `rd_addr`=0x1000, `rd_size`=4, `req_ready`=1, memory responds 2 cycles after each request, AFU pops whenever `empty`=0.
  - Response: `req_addr`=0x40,0x41,0x42,0x43; data arrives in order; `rd_done` the cycle after the 4th pop.
- Backpressure:
  - Stimulus: `rd_size`=40, AFU never pops, FIFO_DEPTH=16.
  - Response: exactly 16 requests issued, then `req_valid`=0. After one pop, exactly one more request.
- Zero size:
  - Stimulus: `rd_size`=0.
  - Response: `rd_done`=1 one cycle after `rd_go`; `req_valid` never asserted.
- Illegal pop and ignored go:
  - Stimulus: `rd_en`=1 with `empty`=1; `rd_go` pulsed during REQ with a different address.
  - Response: no underflow; the original address sequence continues unchanged.
- Reset mid-transfer:
  - Stimulus: assert `rst` after 3 of 8 requests.
  - Response: immediately `empty`=1, `req_valid`=0, `rd_done`=0. A new `rd_go` then completes normally.
- Stats (`DMA_RD_STATS_EN` defined):
  - Stimulus: `req_ready`=0 for 5 cycles during REQ.
  - Response: `stall_cycles`=5; reads 0 after the next `rd_go`.
